// File: rtl/qos_ingress_classifier.sv
// rtl/qos_ingress_classifier.sv - QoS ingress classifier: one-word hold stage steering bytes into four class FIFOs
module qos_ingress_classifier #(
    parameter int DATA_WIDTH   = 8,
    parameter int DROP_ON_FULL = 0,
    parameter int STALL_LIMIT  = 16,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Full,
    input  logic                  pausa,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic [3:0]            push,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic                  err_stall,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, HOLD, STALL} state_t;

    localparam logic [7:0]           LIMIT   = 8'(STALL_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  hold_data_q;
    logic [1:0]             hold_cls_q;
    logic [7:0]             stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic                   err_q, err_d;
    logic                   push_any, drop, accept, blocked;

    // Class comes only from the hold register, so push cannot glitch on DATA_IN changes
    assign busy     = (state_q != IDLE);
    assign push     = (busy && !Full[hold_cls_q] && !pausa) ? (4'b0001 << hold_cls_q) : 4'b0000;
    assign push_any = |push;
    assign drop     = (DROP_ON_FULL != 0) && busy && Full[hold_cls_q] && !pausa;
    assign in_ready = RESET && (!busy || push_any);
    assign accept   = in_valid && in_ready;
    assign blocked  = busy && !push_any && !drop;

    assign DATA_OUT  = hold_data_q;
    assign drop_cnt  = drop_cnt_q;
    assign err_stall = err_q;

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = HOLD;
            end
            HOLD, STALL: begin
                if (drop) begin
                    state_d     = IDLE;
                    stall_cnt_d = 8'd0;
                    if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_ONE;
                end else if (push_any) begin
                    state_d     = accept ? HOLD : IDLE;
                    stall_cnt_d = 8'd0;
                end else begin
                    state_d = STALL;
                    if (state_q == HOLD)
                        stall_cnt_d = 8'd1;
                    else if (stall_cnt_q != 8'hFF)
                        stall_cnt_d = stall_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (blocked && (stall_cnt_d >= LIMIT)) err_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            hold_data_q <= '0;
            hold_cls_q  <= 2'd0;
            stall_cnt_q <= 8'd0;
            drop_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            err_q       <= err_d;
            if (accept) begin
                hold_data_q <= DATA_IN;
                hold_cls_q  <= DATA_IN[DATA_WIDTH-1:DATA_WIDTH-2];
            end
        end
    end

endmodule

// File: tb/tb_qos_ingress_classifier.sv
// tb/tb_qos_ingress_classifier.sv - scoreboard bench for qos_ingress_classifier (stall and drop variants)
module tb_qos_ingress_classifier;

    logic       CLK = 1'b0;
    logic       RESET0, RESET1;
    logic [7:0] DATA_IN0, DATA_IN1, DATA_OUT0, DATA_OUT1;
    logic       in_valid0, in_valid1, in_ready0, in_ready1;
    logic [3:0] Full0, Full1, push0, push1;
    logic       pausa0, pausa1, err0, err1, busy0, busy1;
    logic [7:0] drop_cnt0;
    logic [1:0] drop_cnt1;

    int checks = 0;
    int errors = 0;
    logic [11:0] q0[$];
    logic [11:0] q1[$];
    logic [11:0] e0, e1;
    logic [7:0]  w1[4];

    always #5 CLK = ~CLK;

    qos_ingress_classifier #(.DATA_WIDTH(8), .DROP_ON_FULL(0), .STALL_LIMIT(16), .CNT_WIDTH(8)) u_dut0 (
        .CLK(CLK), .RESET(RESET0), .DATA_IN(DATA_IN0), .in_valid(in_valid0), .in_ready(in_ready0),
        .Full(Full0), .pausa(pausa0), .DATA_OUT(DATA_OUT0), .push(push0), .drop_cnt(drop_cnt0),
        .err_stall(err0), .busy(busy0)
    );

    qos_ingress_classifier #(.DATA_WIDTH(8), .DROP_ON_FULL(1), .STALL_LIMIT(16), .CNT_WIDTH(2)) u_dut1 (
        .CLK(CLK), .RESET(RESET1), .DATA_IN(DATA_IN1), .in_valid(in_valid1), .in_ready(in_ready1),
        .Full(Full1), .pausa(pausa1), .DATA_OUT(DATA_OUT1), .push(push1), .drop_cnt(drop_cnt1),
        .err_stall(err1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot(input logic [7:0] d);
        return 4'b0001 << d[7:6];
    endfunction

    task automatic send(input int sel, input logic [7:0] d, input bit exp_push);
        bit got = 0;
        if (sel == 0) begin DATA_IN0 = d; in_valid0 = 1'b1; end
        else          begin DATA_IN1 = d; in_valid1 = 1'b1; end
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge CLK);
            if ((sel == 0) ? in_ready0 : in_ready1) got = 1;
        end
        check("send_accept", {31'd0, got}, 32'd1);
        if (got && exp_push) begin
            if (sel == 0) q0.push_back({onehot(d), d});
            else          q1.push_back({onehot(d), d});
        end
        @(posedge CLK);
        #1;
        if (sel == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (push0 != 4'b0) begin
            if (q0.size() == 0) check("dut0_unexpected_push", {28'd0, push0}, 32'd0);
            else begin
                e0 = q0.pop_front();
                check("dut0_push", {28'd0, push0}, {28'd0, e0[11:8]});
                check("dut0_data", {24'd0, DATA_OUT0}, {24'd0, e0[7:0]});
            end
        end
        if (push1 != 4'b0) begin
            if (q1.size() == 0) check("dut1_unexpected_push", {28'd0, push1}, 32'd0);
            else begin
                e1 = q1.pop_front();
                check("dut1_push", {28'd0, push1}, {28'd0, e1[11:8]});
                check("dut1_data", {24'd0, DATA_OUT1}, {24'd0, e1[7:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        RESET0 = 0; RESET1 = 0;
        DATA_IN0 = 0; DATA_IN1 = 0; in_valid0 = 0; in_valid1 = 0;
        Full0 = 0; Full1 = 0; pausa0 = 0; pausa1 = 0;
        w1[0] = 8'h41; w1[1] = 8'h82; w1[2] = 8'hC3; w1[3] = 8'h04;
        #12;
        check("rst_ready", {31'd0, in_ready0}, 32'd0);
        check("rst_push", {28'd0, push0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_data", {24'd0, DATA_OUT0}, 32'd0);
        check("rst_drop", {24'd0, drop_cnt0}, 32'd0);
        check("rst_err", {31'd0, err0}, 32'd0);
        @(posedge CLK); #1;
        RESET0 = 1; RESET1 = 1;

        // Scenario 1: back-to-back classes, one word per cycle
        for (int i = 0; i < 4; i++) begin
            DATA_IN0 = w1[i]; in_valid0 = 1'b1;
            @(negedge CLK);
            check("s1_ready", {31'd0, in_ready0}, 32'd1);
            if (i > 0) check("s1_latency", {28'd0, push0}, {28'd0, onehot(w1[i-1])});
            q0.push_back({onehot(w1[i]), w1[i]});
            @(posedge CLK); #1;
        end
        in_valid0 = 1'b0;
        @(negedge CLK);
        check("s1_last_push", {28'd0, push0}, 32'd1);
        @(posedge CLK); #1;

        // Scenario 2: stall on Full, err_stall after 16 blocked cycles
        Full0 = 4'b0100;
        send(0, 8'h85, 1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                check("s2_no_push", {28'd0, push0}, 32'd0);
                check("s2_not_ready", {31'd0, in_ready0}, 32'd0);
            end
            if (k == 16) check("s2_err_early", {31'd0, err0}, 32'd0);
        end
        @(negedge CLK);
        check("s2_err_set", {31'd0, err0}, 32'd1);
        @(posedge CLK); #1;
        Full0 = 4'b0000;
        @(negedge CLK);
        check("s2_release_push", {28'd0, push0}, 32'h4);
        check("s2_release_data", {24'd0, DATA_OUT0}, 32'h85);
        @(negedge CLK);
        check("s2_one_cycle", {28'd0, push0}, 32'd0);
        check("s2_err_sticky", {31'd0, err0}, 32'd1);

        // Scenario 3: drop on Full
        @(posedge CLK); #1;
        Full1 = 4'b1000;
        send(1, 8'hC0, 0);
        send(1, 8'hC1, 0);
        send(1, 8'h10, 1);
        repeat (3) @(negedge CLK);
        check("s3_drop_cnt", {30'd0, drop_cnt1}, 32'd2);
        check("s3_err", {31'd0, err1}, 32'd0);

        // Scenario 4: pause beats drop
        @(posedge CLK); #1;
        pausa1 = 1'b1; Full1 = 4'b0001;
        send(1, 8'h22, 1);
        repeat (5) begin
            @(negedge CLK);
            check("s4_no_push", {28'd0, push1}, 32'd0);
        end
        check("s4_busy", {31'd0, busy1}, 32'd1);
        check("s4_no_drop", {30'd0, drop_cnt1}, 32'd2);
        @(posedge CLK); #1;
        pausa1 = 1'b0; Full1 = 4'b0000;
        @(negedge CLK);
        check("s4_resume", {28'd0, push1}, 32'h1);

        // Scenario 5: asynchronous reset in the middle of a stall
        @(posedge CLK); #1;
        pausa1 = 1'b1;
        send(1, 8'h33, 0);
        repeat (20) @(negedge CLK);
        check("s5_err_pre", {31'd0, err1}, 32'd1);
        #2;
        RESET1 = 1'b0;
        #1;
        check("s5_push", {28'd0, push1}, 32'd0);
        check("s5_busy", {31'd0, busy1}, 32'd0);
        check("s5_drop", {30'd0, drop_cnt1}, 32'd0);
        check("s5_err", {31'd0, err1}, 32'd0);
        check("s5_ready", {31'd0, in_ready1}, 32'd0);
        @(posedge CLK); #1;
        RESET1 = 1'b1; pausa1 = 1'b0;
        send(1, 8'h41, 1);
        @(negedge CLK);
        check("s5_after_push", {28'd0, push1}, 32'h2);

        // Scenario 6: drop counter saturates
        @(posedge CLK); #1;
        Full1 = 4'b1111;
        for (int i = 0; i < 6; i++) send(1, 8'(i * 8'h41), 0);
        repeat (2) @(negedge CLK);
        check("s6_saturate", {30'd0, drop_cnt1}, 32'd3);

        repeat (2) @(negedge CLK);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
